// File: rtl/plru_alloc_pkg.sv
// Shared types and tree-PLRU helpers for the allocation controller.
// Trees are handled at the maximum supported size; callers pass the real depth.
package plru_alloc_pkg;

  localparam int MAX_LEVELS  = 6;
  localparam int MAX_ENTRIES = 1 << MAX_LEVELS;

  typedef enum logic {IDLE, RESP} state_e;

  typedef logic [MAX_ENTRIES-2:0] tree_t;
  typedef logic [MAX_LEVELS-1:0]  idx_t;

  // Point every node on the path of idx away from it (MSB decides at the root).
  function automatic tree_t tree_touch(tree_t tree, idx_t idx, int levels);
    tree_t t;
    idx_t  rem;
    idx_t  node;
    logic  b;
    t    = tree;
    rem  = idx << (MAX_LEVELS - levels);
    node = '0;
    for (int lvl = 0; lvl < MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        b       = rem[MAX_LEVELS-1];
        t[node] = ~b;
        node    = (node << 1) + idx_t'(1) + idx_t'(b);
        rem     = rem << 1;
      end
    end
    return t;
  endfunction

  function automatic idx_t tree_victim(tree_t tree, int levels);
    idx_t idx;
    idx_t node;
    logic b;
    idx  = '0;
    node = '0;
    for (int lvl = 0; lvl < MAX_LEVELS; lvl++) begin
      if (lvl < levels) begin
        b    = tree[node];
        idx  = (idx << 1) | idx_t'(b);
        node = (node << 1) + idx_t'(1) + idx_t'(b);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/plru_alloc_victim.sv
// Victim select: lowest-index invalid entry first, otherwise the tree-PLRU leaf.
module plru_alloc_victim
  import plru_alloc_pkg::*;
#(
  parameter  int ENTRIES  = 16,
  localparam int IdxWidth = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]  valid,
  input  logic [ENTRIES-2:0]  tree,
  output logic [IdxWidth-1:0] idx,
  output logic                replace
);

  logic [IdxWidth-1:0] inv_idx;
  logic [IdxWidth-1:0] plru_idx;

  always_comb begin
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) inv_idx = IdxWidth'(i);
    end
  end

  assign plru_idx = IdxWidth'(tree_victim(tree_t'(tree), IdxWidth));
  assign replace  = &valid;
  assign idx      = replace ? plru_idx : inv_idx;

endmodule

// File: rtl/plru_alloc_ctrl.sv
// Allocation/replacement controller: valid bits, tree-PLRU state and a
// one-deep response register with ready/valid handshakes on both sides.
//
// state | meaning
// IDLE  | no response pending, requests always accepted
// RESP  | rsp_* holds a response until rsp_ready_i
module plru_alloc_ctrl
  import plru_alloc_pkg::*;
#(
  parameter  int ENTRIES  = 16,
  localparam int IdxWidth = $clog2(ENTRIES)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic [ENTRIES-1:0]  used_i,
  input  logic [ENTRIES-1:0]  inval_i,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [IdxWidth-1:0] rsp_idx_o,
  output logic [ENTRIES-1:0]  rsp_onehot_o,
  output logic                rsp_replace_o,
  output logic [ENTRIES-1:0]  valid_o,
  output logic                full_o
);

  localparam int NodeCount = ENTRIES - 1;

  state_e               state;
  logic [ENTRIES-1:0]   valid_q;
  logic [ENTRIES-1:0]   valid_d;
  logic [NodeCount-1:0] tree_q;
  logic [NodeCount-1:0] tree_d;
  logic [IdxWidth-1:0]  victim_idx;
  logic                 victim_replace;
  logic [ENTRIES-1:0]   victim_onehot;
  logic                 accept;
  tree_t                tree_work;

  plru_alloc_victim #(.ENTRIES(ENTRIES)) u_victim (
    .valid   (valid_q),
    .tree    (tree_q),
    .idx     (victim_idx),
    .replace (victim_replace)
  );

  assign alloc_ready_o = rst_ni && !flush_i && (state == IDLE || rsp_ready_i);
  assign accept        = alloc_valid_i && alloc_ready_o;
  assign victim_onehot = {{(ENTRIES-1){1'b0}}, 1'b1} << victim_idx;

  // Allocation is OR-ed in after the invalidate so it wins on the same entry.
  assign valid_d = (valid_q & ~inval_i) | (accept ? victim_onehot : '0);

  // Hits in ascending order, then the allocation touch, so later touches win.
  always_comb begin
    tree_work = tree_t'(tree_q);
    for (int i = 0; i < ENTRIES; i++) begin
      if (used_i[i]) tree_work = tree_touch(tree_work, idx_t'(i), IdxWidth);
    end
    if (accept) tree_work = tree_touch(tree_work, idx_t'(victim_idx), IdxWidth);
    tree_d = NodeCount'(tree_work);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state         <= IDLE;
      valid_q       <= '0;
      tree_q        <= '0;
      rsp_idx_o     <= '0;
      rsp_onehot_o  <= '0;
      rsp_replace_o <= 1'b0;
    end else begin
      valid_q <= valid_d;
      tree_q  <= tree_d;
      if (accept) begin
        state         <= RESP;
        rsp_idx_o     <= victim_idx;
        rsp_onehot_o  <= victim_onehot;
        rsp_replace_o <= victim_replace;
      end else if (state == RESP && rsp_ready_i) begin
        state <= IDLE;
      end
    end
  end

  assign rsp_valid_o = (state == RESP);
  assign valid_o     = valid_q;
  assign full_o      = &valid_q;

endmodule
